lcd_responder: RTL and testbench

Synthesizable HD44780-compatible device-side model. It sits on the far end of the LCD bus that the lab3 host writer drives, and accepts its EN/RS/RW/DB write cycles. It decodes commands and characters into a 32-entry DDRAM (2x16 visible) and emulates the busy timing. It exposes a character readout port so VGA/7-seg/testbench logic can display or check the panel contents on boards without a physical LCD.

---
 rtl/lcd_responder_if.sv | 12 +
 rtl/lcd_responder.sv | 220 ++++++++++++++++++++++
 tb/tb_lcd_responder.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_responder_if.sv
// LCD host-side strobes plus the character readout port of lcd_responder.
// The bidirectional data bus stays a plain inout port on the responder.
interface lcd_responder_if;
  logic       lcd_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;

  modport master (output lcd_en, lcd_rs, lcd_rw, rd_addr, input rd_char);
  modport slave  (input lcd_en, lcd_rs, lcd_rw, rd_addr, output rd_char);
endinterface

// File: rtl/lcd_responder.sv
// HD44780-compatible device-side model: 32-entry DDRAM, busy timing, readout port.
// Optional bus read-back is enabled by defining LCD_RESPONDER_READ_EN.
//
// state | meaning
// IDLE  | waiting for a strobe, o_busy low
// EXEC  | decode latched command/data, one cycle
// CLEAR | fill DDRAM with 0x20, one entry per cycle
// BUSY  | down-counter running to terminal count
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 82000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  lcd_responder_if.slave  bus,
  inout  wire  [7:0]      io_lcd_data,
  output logic            o_busy,
  output logic [6:0]      o_ac,
  output logic            o_display_on,
  output logic            o_two_line,
  output logic            o_overrun
);
  localparam int CW = $clog2(CLEAR_CYCLES + 1);
  // The EXEC cycle is the first busy cycle, so BUSY runs one cycle less.
  localparam int BUSY_LD = BUSY_CYCLES - 1;
  localparam int HOME_LD = CLEAR_CYCLES - 1;
  localparam int CLR_LD  = (CLEAR_CYCLES > 33) ? CLEAR_CYCLES - 33 : 0;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR, S_BUSY} state_t;

  state_t        r_state, w_state_nxt;
  logic [4:0]    r_fill, w_fill_nxt;
  logic          r_clr_cmd, w_clr_cmd_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [6:0]    r_ac, w_ac_nxt;
  logic          r_id, w_id_nxt;
  logic          r_disp, w_disp_nxt;
  logic          r_two, w_two_nxt;
  logic          r_ovr, w_ovr_nxt;
  logic [7:0]    r_cmd, w_cmd_nxt;
  logic          r_rs, w_rs_nxt;
  logic [2:0]    r_sync [SYNC_STAGES];
  logic          r_en_d;
  logic          w_en_s, w_rs_s, w_rw_s, w_strobe;
  logic          w_we;
  logic [4:0]    w_waddr;
  logic [7:0]    w_wdata;
  logic          w_vis;
  logic [4:0]    w_idx;
  logic [7:0]    r_ddram [32];
  logic [7:0]    r_rd_char;

  function automatic logic [6:0] f_step(input logic [6:0] ac, input logic inc);
    logic [6:0] nxt;
    if (inc) nxt = (ac == 7'h27) ? 7'h40 : (ac == 7'h67) ? 7'h00 : ac + 7'd1;
    else     nxt = (ac == 7'h00) ? 7'h67 : (ac == 7'h40) ? 7'h27 : ac - 7'd1;
    return nxt;
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_en_d <= 1'b0;
    end else begin
      r_sync[0] <= {bus.lcd_en, bus.lcd_rs, bus.lcd_rw};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_en_d <= w_en_s;
    end
  end

  assign {w_en_s, w_rs_s, w_rw_s} = r_sync[SYNC_STAGES-1];
  assign w_strobe = r_en_d & ~w_en_s;
  // Visible rows live at 0x00-0x0F and 0x40-0x4F; AC[6] selects the row.
  assign w_vis    = (r_ac[6:4] == 3'b000) || (r_ac[6:4] == 3'b100);
  assign w_idx    = {r_ac[6], r_ac[3:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= S_CLEAR;
      r_fill    <= '0;
      r_clr_cmd <= 1'b0;
      r_cnt     <= '0;
      r_ac      <= '0;
      r_id      <= 1'b1;
      r_disp    <= 1'b0;
      r_two     <= 1'b0;
      r_ovr     <= 1'b0;
      r_cmd     <= '0;
      r_rs      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_fill    <= w_fill_nxt;
      r_clr_cmd <= w_clr_cmd_nxt;
      r_cnt     <= w_cnt_nxt;
      r_ac      <= w_ac_nxt;
      r_id      <= w_id_nxt;
      r_disp    <= w_disp_nxt;
      r_two     <= w_two_nxt;
      r_ovr     <= w_ovr_nxt;
      r_cmd     <= w_cmd_nxt;
      r_rs      <= w_rs_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_fill_nxt    = r_fill;
    w_clr_cmd_nxt = r_clr_cmd;
    w_cnt_nxt     = r_cnt;
    w_ac_nxt      = r_ac;
    w_id_nxt      = r_id;
    w_disp_nxt    = r_disp;
    w_two_nxt     = r_two;
    w_ovr_nxt     = r_ovr;
    w_cmd_nxt     = r_cmd;
    w_rs_nxt      = r_rs;
    w_we          = 1'b0;
    w_waddr       = '0;
    w_wdata       = '0;
    case (r_state)
      S_IDLE: begin
        if (w_strobe && !w_rw_s) begin
          w_state_nxt = S_EXEC;
          w_cmd_nxt   = io_lcd_data;
          w_rs_nxt    = w_rs_s;
        end
      end
      S_EXEC: begin
        w_state_nxt = (BUSY_LD > 0) ? S_BUSY : S_IDLE;
        w_cnt_nxt   = CW'(BUSY_LD);
        if (r_rs) begin
          w_we     = w_vis;
          w_waddr  = w_idx;
          w_wdata  = r_cmd;
          w_ac_nxt = f_step(r_ac, r_id);
        end else begin
          casez (r_cmd)
            8'b1???????: w_ac_nxt = r_cmd[6:0];
            8'b01??????: ;
            8'b001?????: w_two_nxt = r_cmd[3];
            8'b0001????: if (!r_cmd[3]) w_ac_nxt = f_step(r_ac, r_cmd[2]);
            8'b00001???: w_disp_nxt = r_cmd[2];
            8'b000001??: w_id_nxt = r_cmd[1];
            8'b0000001?: begin
              w_ac_nxt    = '0;
              w_cnt_nxt   = CW'(HOME_LD);
              w_state_nxt = (HOME_LD > 0) ? S_BUSY : S_IDLE;
            end
            8'b00000001: begin
              w_state_nxt   = S_CLEAR;
              w_fill_nxt    = '0;
              w_clr_cmd_nxt = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        w_we       = 1'b1;
        w_waddr    = r_fill;
        w_wdata    = 8'h20;
        w_fill_nxt = r_fill + 5'd1;
        if (r_fill == 5'd31) begin
          w_state_nxt = S_IDLE;
          if (r_clr_cmd) begin
            w_ac_nxt      = '0;
            w_id_nxt      = 1'b1;
            w_clr_cmd_nxt = 1'b0;
            w_cnt_nxt     = CW'(CLR_LD);
            w_state_nxt   = (CLR_LD > 0) ? S_BUSY : S_IDLE;
          end
        end
      end
      S_BUSY: begin
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= CW'(1)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_strobe && !w_rw_s && (r_state != S_IDLE)) w_ovr_nxt = 1'b1;
`ifdef LCD_RESPONDER_READ_EN
    if (w_strobe && w_rw_s && w_rs_s && (r_state == S_IDLE || r_state == S_BUSY))
      w_ac_nxt = f_step(r_ac, r_id);
`endif
  end

  always_ff @(posedge i_clk) begin
    if (w_we) r_ddram[w_waddr] <= w_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rd_char <= '0;
    else          r_rd_char <= r_ddram[bus.rd_addr];
  end

`ifdef LCD_RESPONDER_READ_EN
  logic       r_oe;
  logic [7:0] r_dout;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_oe   <= 1'b0;
      r_dout <= '0;
    end else begin
      r_oe   <= w_en_s & w_rw_s;
      r_dout <= w_rs_s ? (w_vis ? r_ddram[w_idx] : 8'h20) : {o_busy, r_ac};
    end
  end
  assign io_lcd_data = r_oe ? r_dout : 8'hzz;
`else
  assign io_lcd_data = 8'hzz;
`endif

  assign bus.rd_char   = r_rd_char;
  assign o_busy        = (r_state != S_IDLE);
  assign o_ac          = r_ac;
  assign o_display_on  = r_disp;
  assign o_two_line    = r_two;
  assign o_overrun     = r_ovr;
endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: table of host writes with expected AC and
// busy length, plus hand sequences for clear, overrun, reset and read cycles.
module tb_lcd_responder;
  localparam int BUSY_CYC = 20;
  localparam int CLR_CYC  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lcd_responder_if bus();
  wire  [7:0] lcd_data;
  logic [7:0] host_data;
  logic       host_oe;
  assign lcd_data = host_oe ? host_data : 8'hzz;

  logic       busy, disp, two, ovr;
  logic [6:0] ac;

  lcd_responder #(.BUSY_CYCLES(BUSY_CYC), .CLEAR_CYCLES(CLR_CYC), .SYNC_STAGES(2)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .io_lcd_data(lcd_data),
    .o_busy(busy), .o_ac(ac), .o_display_on(disp), .o_two_line(two), .o_overrun(ovr)
  );

  typedef struct {
    logic       rs;
    logic [7:0] d;
    logic [6:0] exp_ac;
    int         exp_busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  logic [7:0] exp_mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    bus.lcd_rs = rs;
    bus.lcd_rw = rw;
    host_data  = d;
    host_oe    = !rw;
    bus.lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    bus.lcd_en = 1'b0;
  endtask

  // Waits (bounded) for busy to rise, then counts the cycles it stays high.
  task automatic wait_busy(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    if (seen) begin
      n = 1;
      for (int k = 0; k < 200; k++) begin
        @(negedge clk);
        if (!busy) break;
        n++;
      end
    end
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, output int n);
    strobe(rs, 1'b0, d);
    wait_busy(n);
  endtask

  task automatic rd_check(input int idx, input logic [7:0] exp, input string name);
    @(negedge clk);
    bus.rd_addr = 5'(idx);
    @(negedge clk);
    chk($sformatf("%s[%0d]", name, idx), bus.rd_char, exp);
  endtask

  task automatic scan(input string name);
    for (int i = 0; i < 32; i++) rd_check(i, exp_mem[i], name);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    int n;
    for (int i = lo; i < hi; i++) begin
      wr(vecs[i].rs, vecs[i].d, n);
      chk($sformatf("v%0d_ac", i), ac, vecs[i].exp_ac);
      chk($sformatf("v%0d_busy_len", i), n, vecs[i].exp_busy);
    end
  endtask

  task automatic count_reset_fill(input string name);
    int n = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk(name, n, 32);
  endtask

  initial begin
    int n;
    bit seen;
    bus.lcd_en = 1'b0; bus.lcd_rs = 1'b0; bus.lcd_rw = 1'b0; bus.rd_addr = '0;
    host_data = '0; host_oe = 1'b1;

    // setup sequence (0..5)
    vecs.push_back('{1'b0, 8'h38, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h0C, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h06, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h80, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h68, 7'h01, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h69, 7'h02, BUSY_CYC});
    // line-2, end of line 1 and invisible address (6..11)
    vecs.push_back('{1'b0, 8'hC0, 7'h40, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h41, 7'h41, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h8F, 7'h0F, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h5A, 7'h10, BUSY_CYC});
    vecs.push_back('{1'b0, 8'hA7, 7'h27, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h42, 7'h40, BUSY_CYC});
    // cursor shifts, wraps, no-ops, display off, return home (12..23)
    vecs.push_back('{1'b0, 8'h10, 7'h27, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h14, 7'h40, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h48, 7'h40, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h18, 7'h40, BUSY_CYC});
    vecs.push_back('{1'b0, 8'hE7, 7'h67, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h14, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h10, 7'h67, BUSY_CYC});
    vecs.push_back('{1'b0, 8'hF0, 7'h70, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h14, 7'h71, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h08, 7'h71, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h02, 7'h00, CLR_CYC});
    vecs.push_back('{1'b0, 8'h00, 7'h00, BUSY_CYC});
    // decrement mode, data write wraps 0x00 -> 0x67 (24..26)
    vecs.push_back('{1'b0, 8'h04, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b0, 8'h80, 7'h00, BUSY_CYC});
    vecs.push_back('{1'b1, 8'h31, 7'h67, BUSY_CYC});

    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 1'b1);
    chk("rst_ac", ac, 7'h00);
    chk("rst_rd_char", bus.rd_char, 8'h00);
    chk("rst_overrun", ovr, 1'b0);
    chk("rst_display_on", disp, 1'b0);
    chk("rst_two_line", two, 1'b0);

    @(posedge clk); #1 rst_n = 1'b1;
    count_reset_fill("rst_fill_busy_len");
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    scan("rst_fill");

    run_vecs(0, 6);
    chk("two_line_on", two, 1'b1);
    chk("display_on", disp, 1'b1);
    rd_check(0, 8'h68, "hi");
    rd_check(1, 8'h69, "hi");

    run_vecs(6, 12);
    exp_mem[0] = 8'h68; exp_mem[1] = 8'h69; exp_mem[15] = 8'h5A; exp_mem[16] = 8'h41;
    scan("lines");

    run_vecs(12, 24);
    chk("display_off", disp, 1'b0);

    run_vecs(24, 27);
    rd_check(0, 8'h31, "dec_write");

    // clear display: full busy period, fill, AC home, increment restored
    wr(1'b0, 8'h01, n);
    chk("clear_busy_len", n, CLR_CYC);
    chk("clear_ac", ac, 7'h00);
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    scan("clear");
    wr(1'b1, 8'h41, n);
    chk("clear_inc_ac", ac, 7'h01);
    rd_check(0, 8'h41, "clear_inc");

    // data strobe while busy is dropped and flagged
    strobe(1'b0, 1'b0, 8'h80);
    seen = 1'b0;
    for (int k = 0; k < 12 && !seen; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("ovr_cmd_busy_seen", seen, 1'b1);
    repeat (10) @(negedge clk);
    strobe(1'b1, 1'b0, 8'h55);
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("ovr_flag", ovr, 1'b1);
    chk("ovr_ac", ac, 7'h00);
    chk("ovr_busy_idle", busy, 1'b0);
    rd_check(0, 8'h41, "ovr_mem");

    // reset in the middle of a busy period
    strobe(1'b0, 1'b0, 8'h38);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_overrun", ovr, 1'b0);
    chk("midrst_busy", busy, 1'b1);
    chk("midrst_two_line", two, 1'b0);
    chk("midrst_rd_char", bus.rd_char, 8'h00);
    @(posedge clk); #1 rst_n = 1'b1;
    count_reset_fill("midrst_fill_busy_len");
    rd_check(0, 8'h20, "midrst_fill");

`ifndef LCD_RESPONDER_READ_EN
    // read strobes do nothing without read-back support
    wr(1'b0, 8'h85, n);
    chk("rw_setup_ac", ac, 7'h05);
    strobe(1'b1, 1'b1, 8'h00);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy) seen = 1'b1;
    end
    chk("rw_no_busy", seen, 1'b0);
    chk("rw_ac", ac, 7'h05);
    chk("rw_overrun", ovr, 1'b0);
`else
    wr(1'b0, 8'h85, n);
    @(negedge clk);
    host_oe = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_rs = 1'b0; bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_status_idle", lcd_data, 8'h05);
    bus.lcd_en = 1'b0;
    repeat (4) @(negedge clk);
    strobe(1'b0, 1'b0, 8'h85);
    for (int k = 0; k < 12 && !busy; k++) @(negedge clk);
    host_oe = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_rs = 1'b0; bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_status_busy", lcd_data, 8'h85);
    bus.lcd_en = 1'b0;
    for (int k = 0; k < 60 && busy; k++) @(negedge clk);
    wr(1'b0, 8'h80, n);
    wr(1'b1, 8'h68, n);
    wr(1'b0, 8'h80, n);
    @(negedge clk);
    host_oe = 1'b0; bus.lcd_rw = 1'b1; bus.lcd_rs = 1'b1; bus.lcd_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rd_data", lcd_data, 8'h68);
    bus.lcd_en = 1'b0;
    repeat (5) @(negedge clk);
    chk("rd_data_ac_step", ac, 7'h01);
    chk("rd_data_no_busy", busy, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
